// File: rtl/pattern_stream_gen_if.sv
// Serial (d, valid, ready) bit-stream link between a pattern source and a detector.
interface pattern_stream_gen_if;
  logic d_o;
  logic v_o;
  logic ready_i;

  modport master (output d_o, output v_o, input ready_i);
  modport slave  (input d_o, input v_o, output ready_i);
endinterface

// File: rtl/pattern_stream_gen.sv
// Serialises a 1..MAX_LEN-bit pattern MSB-first, rep times, with optional idle gaps.
// Define PSG_GAP_FILL_EN to fill gaps with valid LFSR (x^7+x^6+1) bits instead of idles.
module pattern_stream_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [MAX_LEN-1:0]   pat_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic [REP_W-1:0]     rep_i,
  input  logic [GAP_W-1:0]     gap_i,
  pattern_stream_gen_if.master strm,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [REP_W-1:0]     sent_cnt_o
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;

  state_t             r_state, w_state_nxt;
  logic [MAX_LEN-1:0] r_pat, w_pat_nxt;
  logic [IDX_W-1:0]   r_len_m1, w_len_m1_nxt;
  logic [REP_W-1:0]   r_rep, w_rep_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [REP_W-1:0]   r_cnt, w_cnt_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;

  logic               w_xfer;
  logic               w_gap_step;
  logic [LEN_W-1:0]   w_len;
  logic [IDX_W-1:0]   w_len_m1;
  logic [REP_W-1:0]   w_cnt_inc;

  assign w_len     = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
  assign w_len_m1  = IDX_W'(w_len - LEN_W'(1));
  assign w_xfer    = strm.v_o && strm.ready_i;
  assign w_cnt_inc = r_cnt + REP_W'(1);

`ifdef PSG_GAP_FILL_EN
  logic [6:0] r_lfsr;

  // Gap filler is a real transfer, so gap length counts accepted filler bits.
  assign strm.v_o   = (r_state == S_SEND) || (r_state == S_GAP);
  assign strm.d_o   = (r_state == S_SEND) ? r_pat[r_idx] :
                      (r_state == S_GAP)  ? r_lfsr[0]    : 1'b0;
  assign w_gap_step = w_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 7'h7F;
    end else if ((r_state == S_GAP) && w_xfer) begin
      r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    end
  end
`else
  assign strm.v_o   = (r_state == S_SEND);
  assign strm.d_o   = (r_state == S_SEND) && r_pat[r_idx];
  assign w_gap_step = 1'b1;
`endif

  assign busy_o     = (r_state == S_SEND) || (r_state == S_GAP);
  assign done_o     = (r_state == S_FIN);
  assign sent_cnt_o = r_cnt;

  always_comb begin
    w_state_nxt   = r_state;
    w_pat_nxt     = r_pat;
    w_len_m1_nxt  = r_len_m1;
    w_rep_nxt     = r_rep;
    w_gap_nxt     = r_gap;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_gap_cnt_nxt = r_gap_cnt;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_pat_nxt    = pat_i;
          w_len_m1_nxt = w_len_m1;
          w_rep_nxt    = rep_i;
          w_gap_nxt    = gap_i;
          w_cnt_nxt    = '0;
          w_idx_nxt    = w_len_m1;
          if ((w_len == '0) || (rep_i == '0)) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = S_SEND;
          end
        end
      end

      S_SEND: begin
        if (w_xfer) begin
          if (r_idx != '0) begin
            w_idx_nxt = r_idx - IDX_W'(1);
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == r_rep) begin
              w_state_nxt = S_FIN;
            end else if (r_gap == '0) begin
              w_idx_nxt = r_len_m1;
            end else begin
              w_state_nxt   = S_GAP;
              w_gap_cnt_nxt = r_gap;
            end
          end
        end
      end

      S_GAP: begin
        if (w_gap_step) begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
          if (r_gap_cnt == GAP_W'(1)) begin
            w_state_nxt = S_SEND;
            w_idx_nxt   = r_len_m1;
          end
        end
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_len_m1  <= '0;
      r_rep     <= '0;
      r_gap     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pat     <= w_pat_nxt;
      r_len_m1  <= w_len_m1_nxt;
      r_rep     <= w_rep_nxt;
      r_gap     <= w_gap_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

endmodule

// File: doc/pattern_stream_gen.md
Name: pattern_stream_gen

Overview:
- Serial pattern transmitter: the source end of the (d, valid) bit-stream interface consumed by our FSM pattern detectors.
- Serialises a programmable 1..MAX_LEN-bit pattern, MSB-first, a programmable number of times, with optional idle gaps between repetitions.
- Honours downstream backpressure.
- Drives detector benches and on-chip self-test of detector instances.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits.
- LEN_W, 4: width of len_i; must hold MAX_LEN.
- REP_W, 4: width of the repetition count.
- GAP_W, 4: width of the inter-repetition gap count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  request to start a burst; sampled only in IDLE.
- pat_i  in  MAX_LEN  pattern, right-justified; bit len-1 is sent first, bit 0 last.
- len_i  in  LEN_W  pattern length; 0 = no-op; values above MAX_LEN are clamped to MAX_LEN.
- rep_i  in  REP_W  number of repetitions; 0 = no-op.
- gap_i  in  GAP_W  gap length between repetitions; 0 = back-to-back.
- ready_i  in  1  downstream accept; a transfer occurs when v_o && ready_i.
- d_o  out  1  serial data bit.
- v_o  out  1  data valid.
- busy_o  out  1  high in SEND and GAP.
- done_o  out  1  one-cycle completion pulse.
- sent_cnt_o  out  REP_W  number of complete repetitions transferred.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; d_o=0, v_o=0, busy_o=0, done_o=0, sent_cnt_o=0.
  - Internal index and gap counters cleared.
  - Takes effect immediately, including mid-burst; the partial burst is abandoned and not resumed.
- All outputs are registered or decoded from registered state; no combinational path from any input to any output.
- States: IDLE, SEND, GAP, FIN.
- IDLE:
  - start_i=1 latches pat/len/rep/gap and clears sent_cnt_o.
  - If clamped len=0 or rep=0: go to FIN (done_o next cycle, no bits sent).
  - Otherwise: go to SEND with bit index = len-1. First v_o appears the cycle after start is sampled (latency 1).
- SEND:
  - v_o=1; d_o = pattern[index].
  - On a transfer with index>0: decrement index.
  - If ready_i=0, d_o and v_o hold stable until the transfer occurs.
  - On transfer of bit 0: sent_cnt_o increments. Then:
    - If new count == rep: go to FIN.
    - Else if gap=0: stay in SEND with index reloaded to len-1. No bubble: repetitions abut back-to-back.
    - Else: go to GAP with gap counter = gap.
- GAP (feature off):
  - v_o=0.
  - Counter decrements every cycle, independent of ready_i.
  - When counter reaches 1, next state is SEND (index = len-1). Exactly gap idle cycles are inserted.
- FIN:
  - done_o=1 for exactly one cycle; busy_o=0, v_o=0.
  - Next state is IDLE.
  - sent_cnt_o holds its final value until the next accepted start.
- start_i in SEND, GAP or FIN: ignored. pat_i, len_i, rep_i and gap_i changing mid-burst have no effect.
- Because the pattern is sent MSB-first, a shift-in detector's register equals pat_i[len-1:0] on the last bit. Back-to-back repeats therefore exercise the detector's overlapping-match paths.
- Counters: sent_cnt_o saturates at rep; it cannot wrap because rep ≤ 2^REP_W-1.

Optional Feature:
- Macro: PSG_GAP_FILL_EN.
- Defined:
  - In GAP, v_o=1 and d_o = LSB of a 7-bit LFSR (x^7+x^6+1).
  - LFSR seed is 7'h7F, set at reset. It advances only on transfers and does not reset between bursts.
  - The gap counter decrements only on transfers. The GAP filler obeys the same hold-under-backpressure rules as SEND.
  - Purpose: exercises detector false-match rejection.
- Undefined: GAP behaves as above with v_o=0; no LFSR logic is synthesised.

Test Plan:
- Single pattern: pat=8'b01101, len=5, rep=1, gap=0, ready_i=1, start sampled at edge 0.
  -> v_o=1 on cycles 1-5 with d_o=0,1,1,0,1; done_o=1 on cycle 6 only; sent_cnt_o=1; busy_o high on cycles 1-5.
- Back-to-back repeats: same pattern, rep=4, gap=0, ready_i=1.
  -> 20 consecutive valid bits forming (01101)x4 with no bubble; done_o on cycle 21; sent_cnt_o=4.
- Backpressure: rep=1, ready_i=0 for cycles 2-4.
  -> d_o stays 1 and v_o stays 1 through cycles 2-4; full sequence still 0,1,1,0,1; done_o on cycle 9.
- Gaps: rep=2, gap=3, feature off.
  -> bits on cycles 1-5; v_o=0 on cycles 6-8; bits on cycles 9-13; done_o on cycle 14.
  - With PSG_GAP_FILL_EN: cycles 6-8 have v_o=1 carrying the LFSR bits of seed 7'h7F.
- Degenerate inputs and ignored start:
  - len=0, start -> done_o one cycle later, v_o never asserted.
  - len=12 -> treated as len 8.
  - start pulsed during SEND -> ignored; sent_cnt_o unaffected.
- Reset mid-burst: rst_n=0 asynchronously at cycle 3 of a rep=4 burst.
  -> v_o, busy_o and sent_cnt_o go to 0 immediately, with no done_o pulse.
  - After release, a new start produces a full correct burst.
